// File: rtl/mc_control_unit.sv
// Multicycle MIPS main control: Moore FSM that sequences fetch, decode, execute,
// memory and write-back, and drives the datapath strobes and mux selects.
module mc_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [5:0]         opcode,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    S_INIT = 'd0,
    S_IF   = 'd1,
    S_ID   = 'd2,
    S_MADR = 'd3,
    S_MRD  = 'd4,
    S_MWB  = 'd5,
    S_MWR  = 'd6,
    S_REX  = 'd7,
    S_RWB  = 'd8,
    S_BEQ  = 'd9,
    S_JMP  = 'd10,
    S_IEX  = 'd11,
    S_IWB  = 'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q, state_d;

  // Strobes as decoded from the state alone, before the freeze gate.
  logic pc_write_dec, pc_write_cond_dec, mem_write_dec, ir_write_dec, reg_write_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        S_INIT: state_d = S_IF;
        S_IF:   state_d = S_ID;
        S_ID: begin
          case (opcode)
            OP_RTYPE:      state_d = S_REX;
            OP_LW, OP_SW:  state_d = S_MADR;
            OP_BEQ:        state_d = S_BEQ;
            OP_J:          state_d = S_JMP;
            OP_ADDI:       state_d = S_IEX;
            default:       state_d = S_IF;
          endcase
        end
        // Only lw/sw reach MADR; anything else here means the IR changed, so refetch.
        S_MADR: begin
          if (opcode == OP_LW)      state_d = S_MRD;
          else if (opcode == OP_SW) state_d = S_MWR;
          else                      state_d = S_IF;
        end
        S_MRD:  state_d = S_MWB;
        S_REX:  state_d = S_RWB;
        S_IEX:  state_d = S_IWB;
        S_MWB, S_MWR, S_RWB, S_BEQ, S_JMP, S_IWB: state_d = S_IF;
        default: state_d = S_IF;
      endcase
    end
  end

  always_comb begin
    pc_write_dec      = 1'b0;
    pc_write_cond_dec = 1'b0;
    mem_write_dec     = 1'b0;
    ir_write_dec      = 1'b0;
    reg_write_dec     = 1'b0;
    i_or_d            = 1'b0;
    mem_read          = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    alu_op            = 2'b00;
    pc_source         = 2'b00;
    case (state_q)
      S_IF: begin
        mem_read     = 1'b1;
        ir_write_dec = 1'b1;
        pc_write_dec = 1'b1;
        alu_src_b    = 2'b01;
      end
      S_ID: alu_src_b = 2'b11;
      S_MADR, S_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MWB: begin
        reg_write_dec = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_MWR: begin
        mem_write_dec = 1'b1;
        i_or_d        = 1'b1;
      end
      S_REX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write_dec = 1'b1;
        reg_dst       = 1'b1;
      end
      S_BEQ: begin
        alu_src_a         = 1'b1;
        alu_op            = 2'b01;
        pc_write_cond_dec = 1'b1;
        pc_source         = 2'b01;
      end
      S_JMP: begin
        pc_write_dec = 1'b1;
        pc_source    = 2'b10;
      end
      S_IWB: reg_write_dec = 1'b1;
      default: ;
    endcase
  end

  // Architectural side effects are suppressed while the debug unit holds the FSM.
  assign pc_write      = pc_write_dec      & en;
  assign pc_write_cond = pc_write_cond_dec & en;
  assign mem_write     = mem_write_dec     & en;
  assign ir_write      = ir_write_dec      & en;
  assign reg_write     = reg_write_dec     & en;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: directed per-cycle expectations are queued
// by the stimulus and checked by an independent monitor.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;

  mc_control_unit #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [15:0] ctl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  event sample_ev;

  // Packing: pcw pcwc iord mr mw irw mtr rdst rw asa asb[2] aop[2] ps[2]
  function automatic logic [15:0] mk(input logic pcw, pcwc, iord, mr, mw, irw, mtr, rdst, rw, asa,
                                     input logic [1:0] asb, aop, ps);
    return {pcw, pcwc, iord, mr, mw, irw, mtr, rdst, rw, asa, asb, aop, ps};
  endfunction

  logic [15:0] dut_ctl;
  assign dut_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                    reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  // Hand-written expected control words per state (en=1 unless noted).
  logic [15:0] C_ZERO, C_IF, C_ID, C_MADR, C_MRD, C_MWB, C_MWR, C_REX, C_RWB, C_RWB_FRZ;
  logic [15:0] C_BEQ, C_JMP, C_IEX, C_IWB;
  initial begin
    C_ZERO    = 16'h0000;
    C_IF      = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00);
    C_ID      = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
    C_MADR    = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    C_MRD     = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
    C_MWB     = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
    C_MWR     = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
    C_REX     = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00);
    C_RWB     = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
    C_RWB_FRZ = mk(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00);
    C_BEQ     = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
    C_JMP     = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
    C_IEX     = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    C_IWB     = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
  end

  // Monitor: compares the DUT's presented outputs with the oldest expectation.
  initial begin
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (state_dbg === e.st) n_pass++;
        else $display("FAIL %s state: got %0d want %0d", e.tag, state_dbg, e.st);
        n_checks++;
        if (dut_ctl === e.ctl) n_pass++;
        else $display("FAIL %s ctl: got %h want %h", e.tag, dut_ctl, e.ctl);
        n_checks++;
        if (!(mem_read && mem_write)) n_pass++;
        else $display("FAIL %s rd_wr_excl: got mr=%b mw=%b want not both", e.tag, mem_read, mem_write);
      end
    end
  end

  // One cycle: drive inputs just after the edge, queue what this cycle must show.
  task automatic step(input string tag, input logic r, input logic e, input logic [5:0] op,
                      input logic [3:0] st, input logic [15:0] ctl);
    exp_t x;
    @(posedge clk);
    #2;
    rst = r; en = e; opcode = op;
    x.tag = tag; x.st = st; x.ctl = ctl;
    exp_q.push_back(x);
    $display("step %-10s rst=%b en=%b op=%b exp_state=%0d exp_ctl=%h", tag, r, e, op, st, ctl);
  endtask

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  initial begin
    exp_t x;
    rst = 1'b1; en = 1'b0; opcode = 6'b0;
    step("init_hold", 0, 0, OP_R, 4'd0, C_ZERO);
    step("init_go",   0, 1, OP_R, 4'd0, C_ZERO);
    // R-type
    step("r_if",  0, 1, OP_R, 4'd1, C_IF);
    step("r_id",  0, 1, OP_R, 4'd2, C_ID);
    step("r_ex",  0, 1, OP_R, 4'd7, C_REX);
    step("r_wb",  0, 1, OP_R, 4'd8, C_RWB);
    // lw
    step("lw_if", 0, 1, OP_LW, 4'd1, C_IF);
    step("lw_id", 0, 1, OP_LW, 4'd2, C_ID);
    step("lw_ad", 0, 1, OP_LW, 4'd3, C_MADR);
    step("lw_rd", 0, 1, OP_LW, 4'd4, C_MRD);
    step("lw_wb", 0, 1, OP_LW, 4'd5, C_MWB);
    // sw
    step("sw_if", 0, 1, OP_SW, 4'd1, C_IF);
    step("sw_id", 0, 1, OP_SW, 4'd2, C_ID);
    step("sw_ad", 0, 1, OP_SW, 4'd3, C_MADR);
    step("sw_wr", 0, 1, OP_SW, 4'd6, C_MWR);
    // addi
    step("ad_if", 0, 1, OP_ADDI, 4'd1, C_IF);
    step("ad_id", 0, 1, OP_ADDI, 4'd2, C_ID);
    step("ad_ex", 0, 1, OP_ADDI, 4'd11, C_IEX);
    step("ad_wb", 0, 1, OP_ADDI, 4'd12, C_IWB);
    // beq
    step("bq_if", 0, 1, OP_BEQ, 4'd1, C_IF);
    step("bq_id", 0, 1, OP_BEQ, 4'd2, C_ID);
    step("bq_ex", 0, 1, OP_BEQ, 4'd9, C_BEQ);
    // j
    step("j_if",  0, 1, OP_J, 4'd1, C_IF);
    step("j_id",  0, 1, OP_J, 4'd2, C_ID);
    step("j_ex",  0, 1, OP_J, 4'd10, C_JMP);
    // illegal opcode: nop
    step("bad_if", 0, 1, OP_BAD, 4'd1, C_IF);
    step("bad_id", 0, 1, OP_BAD, 4'd2, C_ID);
    // freeze during RWB
    step("fz_if",  0, 1, OP_R, 4'd1, C_IF);
    step("fz_id",  0, 1, OP_R, 4'd2, C_ID);
    step("fz_ex",  0, 1, OP_R, 4'd7, C_REX);
    for (int i = 0; i < 3; i++) step("fz_hold", 0, 0, OP_R, 4'd8, C_RWB_FRZ);
    step("fz_go",  0, 1, OP_R, 4'd8, C_RWB);
    // asynchronous reset in MRD
    step("rs_if",  0, 1, OP_LW, 4'd1, C_IF);
    step("rs_id",  0, 1, OP_LW, 4'd2, C_ID);
    step("rs_ad",  0, 1, OP_LW, 4'd3, C_MADR);
    step("rs_rd",  0, 1, OP_LW, 4'd4, C_MRD);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    x.tag = "rs_async"; x.st = 4'd0; x.ctl = C_ZERO;
    exp_q.push_back(x);
    $display("step %-10s async rst mid-cycle exp_state=0 exp_ctl=0000", "rs_async");
    ->sample_ev;
    step("rs_held", 1, 1, OP_LW, 4'd0, C_ZERO);
    step("rs_rel",  0, 1, OP_LW, 4'd0, C_ZERO);
    step("rs_ifok", 0, 1, OP_LW, 4'd1, C_IF);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish want finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
